// File: rtl/m_io_pkg.sv
// -----------------------------------------------------------------------------
// m_io_pkg
// Shared constants and types for the board I/O blocks (switch debouncer,
// LED driver, 7-segment driver).
//
// Contents:
//   SW_W            number of slide switches
//   LED_W           number of discrete LEDs
//   CLK_HZ          system clock frequency
//   DEBOUNCE_MS     debounce settle time in milliseconds
//   DEBOUNCE_CYCLES settle time expressed in system clocks
//   db_state_e      per-bit debounce state (IDLE / PENDING)
//   f_cnt_w()       width of a counter that must hold 0..cycles
// -----------------------------------------------------------------------------
package m_io_pkg;

  localparam int SW_W            = 5;
  localparam int LED_W           = 8;
  localparam int CLK_HZ          = 16000000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  // IDLE: input agrees with the accepted level, counter parked at zero.
  // PENDING: input disagrees and the counter is accumulating agreement time.
  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  // Counter width able to represent every value from 0 up to 'cycles'.
  function automatic int f_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : m_io_pkg

// File: rtl/m_sw_debounce_if.sv
// -----------------------------------------------------------------------------
// m_sw_debounce_if
// Bundle between the raw switch source and the debouncer, and between the
// debouncer and its consumers (LED / 7-segment blocks).
//
// Signals:
//   SW          raw asynchronous switch levels (driven by the board side)
//   sw_stable   debounced levels
//   sw_rise     one-cycle pulse per bit on a debounced 0->1
//   sw_fall     one-cycle pulse per bit on a debounced 1->0
//   sw_changed  high in any cycle where some rise/fall pulse is high
//   sw_toggle   push-on/push-off level per bit (only with SW_TOGGLE_EN)
//
// Modports:
//   master  board/stimulus side: drives SW, observes the results
//   slave   debouncer side: receives SW, drives the results
//
// Build option: `define SW_TOGGLE_EN to add sw_toggle.
// -----------------------------------------------------------------------------
interface m_sw_debounce_if #(
  parameter int SW_W = m_io_pkg::SW_W
);

  logic [SW_W-1:0] SW;
  logic [SW_W-1:0] sw_stable;
  logic [SW_W-1:0] sw_rise;
  logic [SW_W-1:0] sw_fall;
  logic            sw_changed;
`ifdef SW_TOGGLE_EN
  logic [SW_W-1:0] sw_toggle;
`endif

`ifdef SW_TOGGLE_EN
  modport master (
    output SW,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed,
    input  sw_toggle
  );

  modport slave (
    input  SW,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_changed,
    output sw_toggle
  );
`else
  modport master (
    output SW,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  SW,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );
`endif

endinterface : m_sw_debounce_if

// File: rtl/m_debounce_bit.sv
// -----------------------------------------------------------------------------
// m_debounce_bit
// Single-bit synchroniser + debouncer.
//
// The raw input passes through a two-flop synchroniser; only the second flop
// (r_s2) feeds the debounce logic. A new level is accepted once r_s2 has
// disagreed with the accepted level for DEBOUNCE_CYCLES consecutive clocks.
// A single agreeing sample drops back to IDLE and discards partial progress,
// so any glitch shorter than DEBOUNCE_CYCLES clocks is rejected outright.
// Edge-to-output latency is DEBOUNCE_CYCLES + 2 clocks.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   i_sw      raw asynchronous switch level
//   o_stable  debounced level (registered)
//   o_rise    one-cycle pulse when o_stable goes 0->1 (registered)
//   o_fall    one-cycle pulse when o_stable goes 1->0 (registered)
// -----------------------------------------------------------------------------
module m_debounce_bit
  import m_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = m_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = f_cnt_w(DEBOUNCE_CYCLES);

  // Terminal count: reaching it with a still-disagreeing sample accepts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  db_state_e        r_state;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;

  // Synchroniser, debounce FSM/counter and registered level/edge outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= CNT_ZERO;
      r_state  <= DB_IDLE;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      // Edge pulses last exactly one cycle unless re-asserted below.
      r_rise <= 1'b0;
      r_fall <= 1'b0;

      case (r_state)
        DB_IDLE: begin
          if (r_s2 == r_stable) begin
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            // Only reachable from IDLE when DEBOUNCE_CYCLES is 1: the first
            // differing sample is accepted immediately.
            r_stable <= r_s2;
            r_rise   <= r_s2;
            r_fall   <= ~r_s2;
            r_cnt    <= CNT_ZERO;
          end else begin
            r_cnt   <= CNT_ONE;
            r_state <= DB_PENDING;
          end
        end

        DB_PENDING: begin
          if (r_s2 == r_stable) begin
            // Input bounced back: throw away the partial count.
            r_cnt   <= CNT_ZERO;
            r_state <= DB_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_s2;
            r_rise   <= r_s2;
            r_fall   <= ~r_s2;
            r_cnt    <= CNT_ZERO;
            r_state  <= DB_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_cnt   <= CNT_ZERO;
          r_state <= DB_IDLE;
        end
      endcase
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule : m_debounce_bit

// File: rtl/m_sw_debounce.sv
// -----------------------------------------------------------------------------
// m_sw_debounce
// Synchronises and debounces the board slide switches so that downstream
// LED / 7-segment logic only ever sees clean, stable levels and single-cycle
// edge pulses.
//
// Ports:
//   clk     system clock (16 MHz)
//   reset   synchronous, active-high reset
//   sw_if   m_sw_debounce_if.slave
//             SW (in)          raw switch levels
//             sw_stable (out)  debounced levels
//             sw_rise (out)    per-bit 0->1 pulse
//             sw_fall (out)    per-bit 1->0 pulse
//             sw_changed (out) any rise/fall this cycle
//             sw_toggle (out)  push-on/push-off levels (SW_TOGGLE_EN only)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable clocks needed to accept a level
//                    (legal range 1 .. 2**20)
//
// Build option: `define SW_TOGGLE_EN to add the sw_toggle register. Without
// it the port and logic are absent and everything else is unchanged.
// -----------------------------------------------------------------------------
module m_sw_debounce
  import m_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = m_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  m_sw_debounce_if.slave  sw_if
);

  logic [SW_W-1:0] w_stable;
  logic [SW_W-1:0] w_rise;
  logic [SW_W-1:0] w_fall;

  // Every switch is debounced independently; bits may change together.
  for (genvar g = 0; g < SW_W; g++) begin : g_bit
    m_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .i_sw     (sw_if.SW[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  assign sw_if.sw_stable  = w_stable;
  assign sw_if.sw_rise    = w_rise;
  assign sw_if.sw_fall    = w_fall;
  // OR of registered pulses: coincident with them and glitch-free.
  assign sw_if.sw_changed = |(w_rise | w_fall);

`ifdef SW_TOGGLE_EN
  logic [SW_W-1:0] r_toggle;

  // Push-on/push-off: each bit flips the cycle after its rise pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle <= {SW_W{1'b0}};
    end else begin
      r_toggle <= r_toggle ^ w_rise;
    end
  end

  assign sw_if.sw_toggle = r_toggle;
`endif

endmodule : m_sw_debounce

// File: tb/tb_m_sw_debounce.sv
`timescale 1ns/1ps
module tb_m_sw_debounce;

  localparam int D = 4;
  localparam int W = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  m_sw_debounce_if #(.SW_W(W)) u_if ();

  m_sw_debounce #(.DEBOUNCE_CYCLES(D)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sw_if (u_if.slave)
  );

  always #31.25 clk = ~clk;

  typedef struct {
    int           edge_n;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stable;
  } ev_t;

  ev_t          evq[$];
  logic [W-1:0] togq[$];

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int last_evt_edge = -1;
  logic [W-1:0] last_evt_rise = '0;
  logic [W-1:0] last_evt_fall = '0;

  // Reference model: the synchroniser as a 2-deep delay line and the debounce
  // rule as "last D synchronised samples all equal and different from the
  // accepted level".
  logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_tog;
  logic [W-1:0] win[$];
  logic [W-1:0] cur_sw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input logic [W-1:0] sw, input logic rst);
    logic [W-1:0] sample, r, f;
    ev_t e;
    @(negedge clk);
    u_if.SW = sw;
    reset   = rst;
    cur_sw  = sw;
    edge_cnt++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_tog = '0;
      win.delete();
    end else begin
      m_tog  = m_tog ^ m_rise;
      sample = m_s2;
      win.push_back(sample);
      if (win.size() > D) void'(win.pop_front());
      m_s2 = m_s1;
      m_s1 = sw;
      r = '0; f = '0;
      if (win.size() == D) begin
        for (int b = 0; b < W; b++) begin
          bit same = 1'b1;
          for (int i = 1; i < D; i++) if (win[i][b] != win[0][b]) same = 1'b0;
          if (same && win[0][b] != m_stable[b]) begin
            if (win[0][b]) r[b] = 1'b1; else f[b] = 1'b1;
          end
        end
      end
      m_stable = m_stable ^ (r | f);
      m_rise   = r;
      if ((r | f) != '0) begin
        e.edge_n = edge_cnt; e.rise = r; e.fall = f; e.stable = m_stable;
        evq.push_back(e);
      end
    end
    togq.push_back(m_tog);
  endtask

  task automatic idle(input int n);
    repeat (n) step(cur_sw, 1'b0);
  endtask

  // Monitor: pops expected events whenever the DUT signals a change.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_cnt > 0) begin
        while (evq.size() > 0 && evq[0].edge_n < edge_cnt) begin
          chk("missed_event_edge", 32'(edge_cnt), 32'(evq[0].edge_n));
          void'(evq.pop_front());
        end
        chk("changed_is_or", 32'(u_if.sw_changed), 32'(|(u_if.sw_rise | u_if.sw_fall)));
        chk("rise_fall_excl", 32'(u_if.sw_rise & u_if.sw_fall), 32'(0));
        if (u_if.sw_changed === 1'b1) begin
          last_evt_edge = edge_cnt;
          last_evt_rise = u_if.sw_rise;
          last_evt_fall = u_if.sw_fall;
          if (evq.size() == 0 || evq[0].edge_n != edge_cnt) begin
            chk("unexpected_change", 32'(u_if.sw_rise | u_if.sw_fall), 32'(0));
          end else begin
            chk("rise",   32'(u_if.sw_rise),   32'(evq[0].rise));
            chk("fall",   32'(u_if.sw_fall),   32'(evq[0].fall));
            chk("stable", 32'(u_if.sw_stable), 32'(evq[0].stable));
            void'(evq.pop_front());
          end
        end
`ifdef SW_TOGGLE_EN
        if (togq.size() > 0) begin
          chk("toggle", 32'(u_if.sw_toggle), 32'(togq[0]));
          void'(togq.pop_front());
        end
`else
        if (togq.size() > 0) void'(togq.pop_front());
`endif
      end
    end
  end

  initial begin
    int n0;
    logic v;
    u_if.SW = '0;
    cur_sw  = '0;
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_tog = '0;

    // Reset held 3 clocks with switches already up.
    repeat (3) step(5'b10101, 1'b1);
    @(posedge clk); #1;
    chk("rst_stable",  32'(u_if.sw_stable),  32'(0));
    chk("rst_rise",    32'(u_if.sw_rise),    32'(0));
    chk("rst_fall",    32'(u_if.sw_fall),    32'(0));
    chk("rst_changed", 32'(u_if.sw_changed), 32'(0));
    step(5'b10101, 1'b0);
    n0 = edge_cnt;
    idle(8);
    chk("rst_release_latency", 32'(last_evt_edge), 32'(n0 + 5));
    chk("rst_release_rise",    32'(last_evt_rise), 32'(5'b10101));

    // Clean edges on bit 3.
    step(cur_sw | 5'b01000, 1'b0);
    n0 = edge_cnt;
    idle(8);
    chk("clean_rise_latency", 32'(last_evt_edge), 32'(n0 + 5));
    chk("clean_rise_bits",    32'(last_evt_rise), 32'(5'b01000));
    step(cur_sw & 5'b10111, 1'b0);
    n0 = edge_cnt;
    idle(8);
    chk("clean_fall_latency", 32'(last_evt_edge), 32'(n0 + 5));
    chk("clean_fall_bits",    32'(last_evt_fall), 32'(5'b01000));

    // Glitches on bit 0 shorter than the debounce time.
    repeat (5) begin
      repeat (3) step(cur_sw | 5'b00001, 1'b0);
      repeat (3) step(cur_sw & 5'b11110, 1'b0);
    end
    idle(8);
    chk("glitch_stable0", 32'(u_if.sw_stable[0]), 32'(0));

    // Bounce on bit 1 then settle high.
    v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = ~v;
      step({cur_sw[4:2], v, cur_sw[0]}, 1'b0);
    end
    step(cur_sw | 5'b00010, 1'b0);
    idle(8);

    // Simultaneous change of all bits.
    step(5'b00000, 1'b0);
    idle(8);
    step(5'b11111, 1'b0);
    n0 = edge_cnt;
    idle(8);
    chk("simul_latency", 32'(last_evt_edge), 32'(n0 + 5));
    chk("simul_rise",    32'(last_evt_rise), 32'(5'b11111));

    // Reset in the middle of a pending change on bit 2 (twice).
    repeat (2) begin
      step(5'b00000, 1'b0);
      idle(8);
      step(5'b00100, 1'b0);
      idle(3);
      step(5'b00100, 1'b1);
      step(5'b00100, 1'b0);
      idle(8);
    end

    // Randomised run with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] nsw;
      nsw = cur_sw;
      if ($urandom_range(0, 4) == 0) nsw[$urandom_range(0, W - 1)] ^= 1'b1;
      step(nsw, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    idle(12);
    chk("queue_empty", 32'(evq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_m_sw_debounce
